spi_bus_initiator: RTL and testbench

SPI slave front end for the IO expander that turns serial frames into parallel bus cycles on the internal 8-bit bus. It drives `addrSel`, `en` and `dataBus` to load the address generator, then write to or read back from the addressed register. For reads, it shifts the returned byte out on MISO. It sits between the chip pins (SCK/CS_N/MOSI/MISO) and the internal address/data bus, running on the system clock with the SPI inputs oversampled.

---
 rtl/spi_bus_initiator.sv | 170 +++++++++++++++++
 tb/tb_spi_bus_initiator.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/spi_bus_initiator.sv
// spi_bus_initiator: SPI mode-0 slave that turns a 2-byte frame into cycles on
// the internal 8-bit address/data bus (address strobe, then write or read).
// The optional MISO readback path is built only when SPI_READBACK_EN is defined.
module spi_bus_initiator #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  inout  wire  [7:0] dataBus,
  output logic       addrSel,
  output logic       en,
  output logic       rd
);

  typedef enum logic [3:0] {
    IDLE, CMD, A_STB, A_HOLD,
`ifdef SPI_READBACK_EN
    RD,
`endif
    DATA, W_STB, W_HOLD, DONE
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sck_s, cs_s, mosi_s;
  logic       sck_d;
  logic       sck_q, cs_q, mosi_q, sck_rise, sck_fall;
  logic [2:0] bit_cnt;
  logic [7:0] rx;
  logic [3:0] addr;
  logic       wr;
  logic       bus_oe;
  logic [7:0] bus_out;

  assign sck_q    = sck_s[SYNC_STAGES-1];
  assign cs_q     = cs_s[SYNC_STAGES-1];
  assign mosi_q   = mosi_s[SYNC_STAGES-1];
  assign sck_rise = sck_q & ~sck_d;
  assign sck_fall = ~sck_q & sck_d;

  assign dataBus = bus_oe ? bus_out : 8'hzz;

  // Pin synchronizers plus one extra sck sample for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_s  <= '0;
      cs_s   <= '1;
      mosi_s <= '0;
      sck_d  <= 1'b0;
    end else begin
      sck_s  <= {sck_s[SYNC_STAGES-2:0], sck};
      cs_s   <= {cs_s[SYNC_STAGES-2:0], cs_n};
      mosi_s <= {mosi_s[SYNC_STAGES-2:0], mosi};
      sck_d  <= sck_q;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

`ifdef SPI_READBACK_EN
  logic       rd_cnt;
  logic       seen_rise;
  logic [7:0] tx;
  logic       miso_q;

  assign rd   = (state == RD);
  // MISO only drives while the data byte of a read frame is in flight
  assign miso = miso_q & (state == DATA) & ~wr;

  // Read turnaround timer and TX shifter; the first falling edge seen in DATA
  // before any byte-1 rising edge belongs to byte 0 and is skipped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt    <= 1'b0;
      seen_rise <= 1'b0;
      tx        <= '0;
      miso_q    <= 1'b0;
    end else begin
      rd_cnt <= (state == RD) ? ~rd_cnt : 1'b0;
      if (state == RD) begin
        if (rd_cnt) begin
          tx     <= dataBus;
          miso_q <= dataBus[7];
        end
      end else if (state == DATA && !wr) begin
        if (sck_rise) seen_rise <= 1'b1;
        if (sck_fall && seen_rise) begin
          tx     <= {tx[6:0], 1'b0};
          miso_q <= tx[6];
        end
      end else begin
        seen_rise <= 1'b0;
        miso_q    <= 1'b0;
      end
    end
  end
`else
  assign rd   = 1'b0;
  assign miso = 1'b0;
`endif

  // Next state; a cs_n rise aborts any in-progress state on the next clk
  always_comb begin
    state_n = state;
    if (cs_q && state != IDLE && state != DONE) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:   if (!cs_q) state_n = CMD;
        CMD:    if (sck_rise && bit_cnt == 3'd7) state_n = A_STB;
        A_STB:  state_n = A_HOLD;
`ifdef SPI_READBACK_EN
        A_HOLD: state_n = wr ? DATA : RD;
        RD:     if (rd_cnt) state_n = DATA;
`else
        A_HOLD: state_n = wr ? DATA : DONE;
`endif
        DATA:   if (sck_rise && bit_cnt == 3'd7) state_n = wr ? W_STB : DONE;
        W_STB:  state_n = W_HOLD;
        W_HOLD: state_n = DONE;
        DONE:   if (cs_q) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Bus drive: address during A_STB/A_HOLD, write data during W_STB/W_HOLD
  always_comb begin
    en      = 1'b0;
    addrSel = 1'b1;
    bus_oe  = 1'b0;
    bus_out = {4'b0, addr};
    case (state)
      A_STB:  begin en = 1'b1; addrSel = 1'b0; bus_oe = 1'b1; end
      A_HOLD: begin addrSel = 1'b0; bus_oe = 1'b1; end
      W_STB:  begin en = 1'b1; bus_oe = 1'b1; bus_out = rx; end
      W_HOLD: begin bus_oe = 1'b1; bus_out = rx; end
      default: ;
    endcase
  end

  // RX shifter, bit counter and command latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
      rx      <= '0;
      addr    <= '0;
      wr      <= 1'b0;
    end else begin
      if (state == IDLE) bit_cnt <= '0;
      if ((state == CMD || state == DATA) && sck_rise) begin
        rx      <= {rx[6:0], mosi_q};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (state == CMD && sck_rise && bit_cnt == 3'd7) begin
        wr   <= rx[6];
        addr <= {rx[2:0], mosi_q};
      end
    end
  end

endmodule

// File: tb/tb_spi_bus_initiator.sv
// tb_spi_bus_initiator: drives SPI frames, models the register file on dataBus
// and scores every en strobe against a queue of expected {addrSel, dataBus}.
module tb_spi_bus_initiator;
  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst, sck, cs_n, mosi;
  logic       miso, addrSel, en, rd;
  logic [7:0] model_val;
  wire  [7:0] dataBus;

  int n_tests = 0;
  int n_fail  = 0;
  int en_tot = 0, rd_tot = 0, miso_tot = 0;
  logic [8:0] exp_q[$];

  assign dataBus = (rd === 1'b1) ? model_val : 8'hzz;

  spi_bus_initiator #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .dataBus(dataBus), .addrSel(addrSel), .en(en), .rd(rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Strobe monitor: pops one expectation per en-high cycle
  always @(negedge clk) begin
    if (en === 1'b1) begin
      en_tot++;
      if (exp_q.size() > 0) chk("strobe", {23'b0, addrSel, dataBus}, {23'b0, exp_q.pop_front()});
    end
    if (rd === 1'b1) rd_tot++;
    if (miso === 1'b1) miso_tot++;
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rxb);
    rxb = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = tx[i];
      wclk(HALF);
      sck = 1'b1;
      rxb[i] = miso;
      wclk(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_en"}, {31'b0, en}, 32'd0);
    chk({tag, "_rd"}, {31'b0, rd}, 32'd0);
    chk({tag, "_asel"}, {31'b0, addrSel}, 32'd1);
    chk({tag, "_bus"}, {24'b0, dataBus}, {24'b0, 8'hzz});
    chk({tag, "_miso"}, {31'b0, miso}, 32'd0);
  endtask

  int e0, r0, m0;
  logic [7:0] rxb;

  task automatic fbegin();
    e0 = en_tot; r0 = rd_tot; m0 = miso_tot;
    cs_n = 1'b0;
    wclk(6);
  endtask

  task automatic fend(input string tag, input int exp_en, input int exp_rd);
    wclk(HALF);
    cs_n = 1'b1;
    wclk(10);
    chk({tag, "_en_cnt"}, en_tot - e0, exp_en);
    chk({tag, "_rd_cycles"}, rd_tot - r0, exp_rd);
    chk({tag, "_q_empty"}, exp_q.size(), 0);
    idle_chk(tag);
  endtask

  initial begin
    rst = 1'b0; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0; model_val = 8'hC3;
    wclk(3);
    idle_chk("reset");
    rst = 1'b1;
    wclk(3);

    // Reset in the middle of the command byte
    cs_n = 1'b0;
    wclk(6);
    xfer(8'h83, 5, rxb);
    rst = 1'b0;
    #1;
    idle_chk("midrst");
    cs_n = 1'b1; sck = 1'b0;
    wclk(3);
    rst = 1'b1;
    wclk(3);

    // Write 0x5A to address 3
    exp_q.push_back({1'b0, 8'h03});
    exp_q.push_back({1'b1, 8'h5A});
    fbegin();
    xfer(8'h83, 8, rxb);
    xfer(8'h5A, 8, rxb);
    fend("write", 2, 0);
    chk("write_miso", miso_tot - m0, 0);

    // Read frame
`ifdef SPI_READBACK_EN
    exp_q.push_back({1'b0, 8'h07});
    fbegin();
    xfer(8'h07, 8, rxb);
    xfer(8'h00, 8, rxb);
    chk("read_miso_byte", {24'b0, rxb}, {24'b0, 8'hC3});
    fend("read", 1, 2);
`else
    exp_q.push_back({1'b0, 8'h02});
    fbegin();
    xfer(8'h02, 8, rxb);
    xfer(8'h00, 8, rxb);
    chk("read_miso_byte", {24'b0, rxb}, 32'd0);
    fend("read", 1, 0);
    chk("read_miso_hi", miso_tot - m0, 0);
`endif

    // Abort after 5 bits of the write data byte
    exp_q.push_back({1'b0, 8'h04});
    fbegin();
    xfer(8'h84, 8, rxb);
    xfer(8'hA5, 5, rxb);
    cs_n = 1'b1;
    wclk(5);
    idle_chk("abort_now");
    fend("abort", 1, 0);

    // Three-byte frame: third byte ignored
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b1, 8'hFF});
    fbegin();
    xfer(8'h81, 8, rxb);
    xfer(8'hFF, 8, rxb);
    xfer(8'h12, 8, rxb);
    fend("three", 2, 0);

    // Frame after the abort still works
    exp_q.push_back({1'b0, 8'h0F});
    exp_q.push_back({1'b1, 8'h3C});
    fbegin();
    xfer(8'h8F, 8, rxb);
    xfer(8'h3C, 8, rxb);
    fend("write2", 2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
